// File: rtl/connect_flit_pkg.sv
// Shared flit format and serializer state encoding for the injection path.
// Flit geometry mirrors connect_parameters.v; defaults apply when it is absent.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif
`ifndef DEST_BITS
`define DEST_BITS 4
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH (`FLIT_DATA_WIDTH + `DEST_BITS + `VC_BITS + 2)
`endif

package connect_flit_pkg;

    localparam int FLIT_DATA_WIDTH = `FLIT_DATA_WIDTH;
    localparam int DEST_BITS       = `DEST_BITS;
    localparam int VC_BITS         = `VC_BITS;

    typedef struct packed {
        logic                       valid;
        logic                       is_tail;
        logic [DEST_BITS-1:0]       dst;
        logic [VC_BITS-1:0]         vc;
        logic [FLIT_DATA_WIDTH-1:0] data;
    } flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/msg_flit_serializer.sv
// Splits one wide message into body flits plus a tail flit for the flit FIFO.
// Optional perf counters enabled by defining MSG_SER_PERF_CNT_EN.
module msg_flit_serializer
    import connect_flit_pkg::*;
#(
    parameter int MSG_WIDTH = 4 * `FLIT_DATA_WIDTH,
    parameter int VC        = 0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [MSG_WIDTH-1:0]   msg_data,
    input  logic [DEST_BITS-1:0]   msg_dst,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    output logic [`FLIT_WIDTH-1:0] flit_out,
    output logic                   flit_out_valid,
    input  logic                   flit_out_ready,
`ifdef MSG_SER_PERF_CNT_EN
    output logic [31:0]            perf_msgs,
    output logic [31:0]            perf_flits,
    output logic [31:0]            perf_stall,
`endif
    output logic                   busy
);

    localparam int FDW       = FLIT_DATA_WIDTH;
    localparam int NUM_FLITS = (MSG_WIDTH + FDW - 1) / FDW;
    localparam int BEAT_W    = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
    localparam int BUF_W     = NUM_FLITS * FDW;
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(NUM_FLITS - 1);

    ser_state_e           state;
    logic [BEAT_W-1:0]    beat;
    logic [BUF_W-1:0]     msg_buf;
    logic [DEST_BITS-1:0] dst_q;

    logic  sending;
    logic  is_tail;
    logic  msg_fire;
    logic  flit_fire;
    flit_t flit;

    assign sending   = (state == SEND);
    assign is_tail   = (beat == LAST);
    // Tail fire frees the slot in the same cycle for bubble-free packets.
    assign msg_ready = RST_N & (~sending | (is_tail & flit_out_ready));
    assign msg_fire  = msg_valid & msg_ready;
    assign flit_fire = sending & flit_out_ready;

    always_comb begin
        flit = '0;
        if (sending) begin
            flit.valid   = 1'b1;
            flit.is_tail = is_tail;
            flit.dst     = dst_q;
            flit.vc      = VC_BITS'(VC);
            flit.data    = msg_buf[int'(beat) * FDW +: FDW];
        end
    end

    assign flit_out       = flit;
    assign flit_out_valid = sending;
    assign busy           = sending;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            beat    <= '0;
            msg_buf <= '0;
            dst_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (msg_fire) begin
                        msg_buf <= BUF_W'(msg_data);
                        dst_q   <= msg_dst;
                        beat    <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (flit_fire) begin
                        if (!is_tail) begin
                            beat <= beat + 1'b1;
                        end else if (msg_fire) begin
                            msg_buf <= BUF_W'(msg_data);
                            dst_q   <= msg_dst;
                            beat    <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MSG_SER_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_msgs  <= '0;
            perf_flits <= '0;
            perf_stall <= '0;
        end else begin
            if (msg_fire)
                perf_msgs <= perf_msgs + 32'd1;
            if (flit_fire)
                perf_flits <= perf_flits + 32'd1;
            if (sending && !flit_out_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
